znmi_multi: RTL and testbench

Multi-source NMI generator, the parametrised successor of the single-pair NMI block in the Z80 subsystem.
- Accepts NSRC independent falling-edge requests (slavespi, debug button, watchpoint, ...), each with a mask bit and a sticky pending flag.
- On the next INT start, serves the highest-priority pending source: drives an NMI pulse of programmable length and reports the served source ID to the port/memory-mapping logic.
- Raises in_nmi, which maps the last RAM page into 0000-3FFF.
- Leaves NMI after a programmable number of refresh cycles following an exit write.

---
 rtl/znmi_multi.sv | 112 +++++++++++
 tb/tb_znmi_multi.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/znmi_multi.sv
// Multi-source NMI generator: fixed-priority arbitration of masked falling-edge requests,
// programmable NMI pulse and refresh-counted exit. Optional macro: ZNMI_IMMEDIATE_EN.
module znmi_multi #(
    parameter int NSRC      = 4,
    parameter int SRCW      = 2,
    parameter int PULSE_LEN = 16,
    parameter int CLR_DELAY = 3
) (
    input  logic            fclk,
    input  logic            rst_n,
    input  logic            zpos,
    input  logic            int_start,
    input  logic [NSRC-1:0] set_nmi,
    input  logic [NSRC-1:0] src_mask,
    input  logic            clr_nmi,
    input  logic            rfsh_n,
    output logic            in_nmi,
    output logic            gen_nmi,
    output logic [SRCW-1:0] nmi_src,
    output logic [NSRC-1:0] pending
);

    localparam logic [7:0] PULSE_INIT = 8'(PULSE_LEN);
    localparam logic [3:0] CLR_INIT   = 4'(CLR_DELAY);

    logic [NSRC-1:0] prev_q, prev_d;
    logic [NSRC-1:0] pending_q, pending_d;
    logic            in_nmi_q, in_nmi_d;
    logic [SRCW-1:0] nmi_src_q, nmi_src_d;
    logic [7:0]      pulse_cnt_q, pulse_cnt_d;
    logic [3:0]      clr_cnt_q, clr_cnt_d;
    logic            pending_clr_q, pending_clr_d;

    logic [NSRC-1:0] req;
    logic [SRCW-1:0] winner;
    logic            serve;
    logic            drop;

    // Lowest index wins: scan downwards so the last hit is the smallest set index.
    always_comb begin
        winner = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pending_q[i]) winner = SRCW'(i);
        end
    end

    assign req  = prev_q & ~set_nmi & src_mask;
    assign drop = pending_clr_q && (clr_cnt_q == 4'd0);
`ifdef ZNMI_IMMEDIATE_EN
    assign serve = zpos & ~in_nmi_q & (|pending_q);
`else
    assign serve = int_start & ~in_nmi_q & (|pending_q);
`endif

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        prev_d        = set_nmi;
        pending_d     = pending_q | req;
        in_nmi_d      = in_nmi_q;
        nmi_src_d     = nmi_src_q;
        pulse_cnt_d   = pulse_cnt_q;
        clr_cnt_d     = clr_cnt_q;
        pending_clr_d = pending_clr_q;

        // Serving clears the winner after the OR, so a same-cycle request is absorbed.
        if (serve) begin
            in_nmi_d           = 1'b1;
            nmi_src_d          = winner;
            pending_d[winner]  = 1'b0;
            pulse_cnt_d        = PULSE_INIT;
        end else begin
            if (pulse_cnt_q != 8'd0) pulse_cnt_d = pulse_cnt_q - 8'd1;
            if (drop) in_nmi_d = 1'b0;
        end

        if (clr_nmi) begin
            clr_cnt_d     = CLR_INIT;
            pending_clr_d = 1'b1;
        end else if (drop) begin
            pending_clr_d = 1'b0;
        end else if (zpos && !rfsh_n && clr_cnt_q != 4'd0) begin
            clr_cnt_d = clr_cnt_q - 4'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; all of it is reset.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q        <= '0;
            pending_q     <= '0;
            in_nmi_q      <= 1'b0;
            nmi_src_q     <= '0;
            pulse_cnt_q   <= '0;
            clr_cnt_q     <= '0;
            pending_clr_q <= 1'b0;
        end else begin
            prev_q        <= prev_d;
            pending_q     <= pending_d;
            in_nmi_q      <= in_nmi_d;
            nmi_src_q     <= nmi_src_d;
            pulse_cnt_q   <= pulse_cnt_d;
            clr_cnt_q     <= clr_cnt_d;
            pending_clr_q <= pending_clr_d;
        end
    end

    assign in_nmi  = in_nmi_q;
    assign gen_nmi = (pulse_cnt_q != 8'd0);
    assign nmi_src = nmi_src_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_znmi_multi.sv
// Self-checking bench for znmi_multi: served source IDs are pushed to a scoreboard at
// stimulus time and popped when in_nmi rises; pulse length is measured per NMI.
module tb_znmi_multi;

    localparam int NSRC      = 4;
    localparam int SRCW      = 2;
    localparam int PULSE_LEN = 16;
    localparam int CLR_DELAY = 3;

    logic            fclk = 1'b0;
    logic            rst_n = 1'b0;
    logic            zpos = 1'b0;
    logic            int_start = 1'b0;
    logic [NSRC-1:0] set_nmi = '1;
    logic [NSRC-1:0] src_mask = '1;
    logic            clr_nmi = 1'b0;
    logic            rfsh_n = 1'b1;
    logic            in_nmi;
    logic            gen_nmi;
    logic [SRCW-1:0] nmi_src;
    logic [NSRC-1:0] pending;

    int n_checks = 0;
    int n_fail   = 0;
    int src_q[$];

    znmi_multi #(
        .NSRC(NSRC), .SRCW(SRCW), .PULSE_LEN(PULSE_LEN), .CLR_DELAY(CLR_DELAY)
    ) dut (
        .fclk(fclk), .rst_n(rst_n), .zpos(zpos), .int_start(int_start),
        .set_nmi(set_nmi), .src_mask(src_mask), .clr_nmi(clr_nmi), .rfsh_n(rfsh_n),
        .in_nmi(in_nmi), .gen_nmi(gen_nmi), .nmi_src(nmi_src), .pending(pending)
    );

    always #5 fclk = ~fclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge fclk);
            #1;
        end
    endtask

    task automatic drop_req(input logic [NSRC-1:0] bits);
        set_nmi = ~bits;
        tick();
        set_nmi = '1;
    endtask

    task automatic fire_int(input int exp_src);
        src_q.push_back(exp_src);
        int_start = 1'b1;
        tick();
        int_start = 1'b0;
    endtask

    task automatic rfsh_strobe(input int n);
        repeat (n) begin
            zpos = 1'b1; rfsh_n = 1'b0;
            tick();
            zpos = 1'b0; rfsh_n = 1'b1;
            tick();
        end
    endtask

    task automatic pulse_clr();
        clr_nmi = 1'b1;
        tick();
        clr_nmi = 1'b0;
    endtask

    // Monitor: scoreboard compare on in_nmi rise, pulse width on gen_nmi fall.
    logic in_nmi_prev = 1'b0;
    int   gen_cnt = 0;
    always @(negedge fclk) begin
        if (!rst_n) begin
            gen_cnt     = 0;
            in_nmi_prev = 1'b0;
        end else begin
            if (in_nmi && !in_nmi_prev) begin
                if (src_q.size() == 0) check("sb_depth", 0, 1);
                else check("sb_nmi_src", 32'(nmi_src), 32'(src_q.pop_front()));
            end
            in_nmi_prev = in_nmi;
            if (gen_nmi) gen_cnt++;
            else if (gen_cnt != 0) begin
                check("pulse_len", gen_cnt, PULSE_LEN);
                gen_cnt = 0;
            end
        end
    end

    initial begin
        tick(2);
        check("rst_in_nmi",  32'(in_nmi),  0);
        check("rst_gen_nmi", 32'(gen_nmi), 0);
        check("rst_nmi_src", 32'(nmi_src), 0);
        check("rst_pending", 32'(pending), 0);
        rst_n = 1'b1;
        tick(3);

`ifdef ZNMI_IMMEDIATE_EN
        // Immediate mode: request served on the next zpos, no int_start.
        drop_req(4'b0010);
        check("imm_pending", 32'(pending), 32'b0010);
        tick(2);
        check("imm_wait_zpos", 32'(in_nmi), 0);
        src_q.push_back(1);
        zpos = 1'b1;
        tick();
        zpos = 1'b0;
        check("imm_in_nmi",  32'(in_nmi),  1);
        check("imm_nmi_src", 32'(nmi_src), 1);
        check("imm_pending_clr", 32'(pending), 0);
        tick(PULSE_LEN + 4);
        check("imm_gen_done", 32'(gen_nmi), 0);
`else
        // 1: single source served.
        drop_req(4'b0100);
        check("t1_pending", 32'(pending), 32'b0100);
        check("t1_no_nmi_yet", 32'(in_nmi), 0);
        fire_int(2);
        check("t1_in_nmi",  32'(in_nmi),  1);
        check("t1_nmi_src", 32'(nmi_src), 2);
        check("t1_pending_clr", 32'(pending), 0);
        check("t1_gen_nmi", 32'(gen_nmi), 1);
        tick(PULSE_LEN + 4);
        check("t1_gen_done", 32'(gen_nmi), 0);
        pulse_clr();
        rfsh_strobe(CLR_DELAY);
        tick(2);
        check("t1_exit", 32'(in_nmi), 0);
        check("t1_src_hold", 32'(nmi_src), 2);

        // 2: two simultaneous requests, priority then second served.
        drop_req(4'b1010);
        check("t2_pending", 32'(pending), 32'b1010);
        fire_int(1);
        check("t2_nmi_src", 32'(nmi_src), 1);
        check("t2_pending_left", 32'(pending), 32'b1000);
        tick(PULSE_LEN + 4);
        pulse_clr();
        rfsh_strobe(CLR_DELAY);
        tick(2);
        check("t2_exit", 32'(in_nmi), 0);
        fire_int(3);
        check("t2_second_src", 32'(nmi_src), 3);
        check("t2_pending_empty", 32'(pending), 0);
        tick(PULSE_LEN + 4);
        pulse_clr();
        rfsh_strobe(CLR_DELAY);
        tick(2);
        check("t2_exit2", 32'(in_nmi), 0);

        // 3: masked source is discarded.
        src_mask = 4'b1110;
        drop_req(4'b0001);
        check("t3_masked_pending", 32'(pending), 0);
        int_start = 1'b1;
        tick();
        int_start = 1'b0;
        tick();
        check("t3_no_nmi", 32'(in_nmi), 0);
        src_mask = '1;

        // 4: clr_nmi restart during countdown.
        drop_req(4'b0001);
        fire_int(0);
        tick(PULSE_LEN + 4);
        pulse_clr();
        rfsh_strobe(2);
        pulse_clr();
        rfsh_strobe(2);
        tick(2);
        check("t4_still_in", 32'(in_nmi), 1);
        rfsh_strobe(1);
        tick(2);
        check("t4_exit", 32'(in_nmi), 0);

        // 5: asynchronous reset mid-pulse.
        drop_req(4'b1010);
        fire_int(1);
        tick(4);
        check("t5_pulse_live", 32'(gen_nmi), 1);
        check("t5_pending_live", 32'(pending), 32'b1000);
        rst_n = 1'b0;
        #1;
        check("t5_gen_nmi", 32'(gen_nmi), 0);
        check("t5_in_nmi",  32'(in_nmi),  0);
        check("t5_pending", 32'(pending), 0);
        check("t5_nmi_src", 32'(nmi_src), 0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
`endif
        check("sb_empty", src_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
